// File: rtl/color_entry_controller_pkg.sv
// Shared types and constants for launchpad colour entry: state encoding and field widths.
package color_entry_controller_pkg;

    localparam int COLOR_W  = 24;
    localparam int DIGITS   = 6;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_ENTRY  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/color_entry_controller_nibble_shifter.sv
// 24-bit MSB-first nibble shift register for colour entry.
// Latency: 1 cycle per shift; no backpressure; clear has priority over shift_en.
module color_nibble_shifter
    import color_entry_controller_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                shift_en,
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [COLOR_W-1:0]  shreg
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {shreg[COLOR_W-NIBBLE_W-1:0], nibble};
        end
    end

endmodule

// File: rtl/color_entry_controller.sv
// Sequences hex-key entry (slot key + six digits) into one 24-bit colour write; optional abort timer via COLOR_ENTRY_TIMEOUT_EN.
// Latency: sixth accepted key -> wr_en the next cycle; all outputs registered; no backpressure, keys outside SELECT/ENTRY are dropped.
module color_entry_controller
    import color_entry_controller_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int SLOT_W         = 2
`ifdef COLOR_ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2**24
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cancel,
    input  logic               key_valid,
    input  logic [3:0]         key_value,
    output logic               busy,
    output logic [2:0]         digit_count,
    output logic               key_err,
    output logic               wr_en,
    output logic [SLOT_W-1:0]  wr_slot,
    output logic [COLOR_W-1:0] wr_color,
    output logic               timeout
);

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic [COLOR_W-1:0]  shreg;
    logic                editing;
    logic                tmo_hit;
    logic                sh_clear;
    logic                sh_shift;

`ifdef COLOR_ENTRY_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] tmr;
`endif

    // A same-cycle key or cancel always beats the timer.
    always_comb begin
        editing = (state == ST_SELECT) || (state == ST_ENTRY);
        tmo_hit = 1'b0;
`ifdef COLOR_ENTRY_TIMEOUT_EN
        tmo_hit = editing && !cancel && !key_valid && (tmr == TMR_LAST);
`endif
        sh_shift = (state == ST_ENTRY) && key_valid && !cancel;
        sh_clear = ((state == ST_IDLE) && start) || (editing && cancel) ||
                   (state == ST_COMMIT) || tmo_hit;
    end

    color_nibble_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .clear    (sh_clear),
        .shift_en (sh_shift),
        .nibble   (key_value),
        .shreg    (shreg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            slot        <= '0;
            busy        <= 1'b0;
            digit_count <= '0;
            key_err     <= 1'b0;
            wr_en       <= 1'b0;
            wr_slot     <= '0;
            wr_color    <= '0;
            timeout     <= 1'b0;
`ifdef COLOR_ENTRY_TIMEOUT_EN
            tmr         <= '0;
`endif
        end else begin
            key_err <= 1'b0;
            wr_en   <= 1'b0;
            timeout <= 1'b0;
`ifdef COLOR_ENTRY_TIMEOUT_EN
            if (editing) tmr <= tmr + 1'b1;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SELECT;
                        busy  <= 1'b1;
`ifdef COLOR_ENTRY_TIMEOUT_EN
                        tmr   <= '0;
`endif
                    end
                end
                ST_SELECT, ST_ENTRY: begin
                    if (cancel || tmo_hit) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        digit_count <= '0;
                        timeout     <= tmo_hit;
                    end else if (key_valid && state == ST_SELECT) begin
                        if (int'(key_value) < NUM_SLOTS) begin
                            slot        <= key_value[SLOT_W-1:0];
                            digit_count <= '0;
                            state       <= ST_ENTRY;
`ifdef COLOR_ENTRY_TIMEOUT_EN
                            tmr         <= '0;
`endif
                        end else begin
                            key_err <= 1'b1;
                        end
                    end else if (key_valid) begin
                        digit_count <= digit_count + 3'd1;
`ifdef COLOR_ENTRY_TIMEOUT_EN
                        tmr         <= '0;
`endif
                        // Sixth digit: the shifter updates this same edge, so build the colour here.
                        if (int'(digit_count) == DIGITS - 1) begin
                            state    <= ST_COMMIT;
                            wr_en    <= 1'b1;
                            wr_slot  <= slot;
                            wr_color <= {shreg[COLOR_W-NIBBLE_W-1:0], key_value};
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    digit_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_color_entry_controller.sv
// Directed table-driven bench for color_entry_controller plus a hand-written timer sequence.
module tb_color_entry_controller;

    logic        clk = 1'b0;
    logic        reset, start, cancel, key_valid;
    logic [3:0]  key_value;
    logic        busy, key_err, wr_en, timeout;
    logic [2:0]  digit_count;
    logic [1:0]  wr_slot;
    logic [23:0] wr_color;

    always #5 clk = ~clk;

    color_entry_controller #(
        .NUM_SLOTS      (4),
        .SLOT_W         (2)
`ifdef COLOR_ENTRY_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cancel      (cancel),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .busy        (busy),
        .digit_count (digit_count),
        .key_err     (key_err),
        .wr_en       (wr_en),
        .wr_slot     (wr_slot),
        .wr_color    (wr_color),
        .timeout     (timeout)
    );

    typedef struct {
        logic        rst, st, cn, kv;
        logic [3:0]  kval;
        logic        busy;
        logic [2:0]  dc;
        logic        kerr, wr;
        logic [1:0]  slot;
        logic [23:0] color;
        logic        tmo;
    } vec_t;

    vec_t        vecs[$];
    logic [1:0]  hs = 2'd0;
    logic [23:0] hc = 24'd0;
    int          passed = 0;
    int          total  = 0;

    task automatic add(input logic rst, st, cn, kv, input logic [3:0] kval,
                       input logic ebusy, input logic [2:0] edc, input logic ekerr, ewr);
        vec_t v;
        v.rst = rst; v.st = st; v.cn = cn; v.kv = kv; v.kval = kval;
        v.busy = ebusy; v.dc = edc; v.kerr = ekerr; v.wr = ewr;
        v.slot = hs; v.color = hc; v.tmo = 1'b0;
        vecs.push_back(v);
    endtask

    // Key press followed by a one-cycle gap.
    task automatic add_key(input logic [3:0] k, input logic ebusy, input logic [2:0] edc, input logic ekerr);
        add(0, 0, 0, 1, k, ebusy, edc, ekerr, 0);
        add(0, 0, 0, 0, 4'd0, ebusy, edc, 1'b0, 0);
    endtask

    task automatic add_commit(input logic [3:0] k, input logic [1:0] s, input logic [23:0] c);
        hs = s; hc = c;
        add(0, 0, 0, 1, k, 1, 3'd6, 0, 1);
        add(0, 0, 0, 0, 4'd0, 0, 3'd0, 0, 0);
    endtask

    task automatic drive(input logic rst, st, cn, kv, input logic [3:0] kval);
        reset = rst; start = st; cancel = cn; key_valid = kv; key_value = kval;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    initial begin
        drive(1, 0, 0, 0, 4'd0);
        // reset state, with start/key activity ignored while reset is high
        add(1, 1, 0, 1, 4'd2, 0, 0, 0, 0);
        add(1, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        // 1: normal commit slot 2 colour FF0080; start+cancel in IDLE -> start wins
        add(0, 1, 1, 0, 4'd0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 4'd0, 1, 0, 0, 0);
        add_key(4'h2, 1, 0, 0);
        add_key(4'hF, 1, 1, 0);
        add(0, 1, 0, 0, 4'd0, 1, 1, 0, 0);      // start outside IDLE ignored
        add_key(4'hF, 1, 2, 0);
        add_key(4'h0, 1, 3, 0);
        add_key(4'h0, 1, 4, 0);
        add_key(4'h8, 1, 5, 0);
        add_commit(4'h0, 2'd2, 24'hFF0080);
        // 2: illegal slot key 7, then slot 1
        add(0, 1, 0, 0, 4'd0, 1, 0, 0, 0);
        add_key(4'h7, 1, 0, 1);
        add_key(4'h1, 1, 0, 0);
        add_key(4'h1, 1, 1, 0);
        add_key(4'h2, 1, 2, 0);
        add_key(4'h3, 1, 3, 0);
        add_key(4'h4, 1, 4, 0);
        add_key(4'h5, 1, 5, 0);
        add_commit(4'h6, 2'd1, 24'h123456);
        // 3: cancel after three digits, then fresh entry to slot 0
        add(0, 1, 0, 0, 4'd0, 1, 0, 0, 0);
        add_key(4'h3, 1, 0, 0);
        add_key(4'hA, 1, 1, 0);
        add_key(4'hB, 1, 2, 0);
        add_key(4'hC, 1, 3, 0);
        add(0, 0, 1, 0, 4'd0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 4'd0, 1, 0, 0, 0);
        add_key(4'h0, 1, 0, 0);
        add_key(4'hD, 1, 1, 0);
        add_key(4'hE, 1, 2, 0);
        add_key(4'hA, 1, 3, 0);
        add_key(4'hD, 1, 4, 0);
        add_key(4'h0, 1, 5, 0);
        add_commit(4'h1, 2'd0, 24'hDEAD01);
        // 4: cancel together with the sixth digit drops the key and the write
        add(0, 1, 0, 0, 4'd0, 1, 0, 0, 0);
        add_key(4'h3, 1, 0, 0);
        add_key(4'h9, 1, 1, 0);
        add_key(4'h9, 1, 2, 0);
        add_key(4'h9, 1, 3, 0);
        add_key(4'h9, 1, 4, 0);
        add_key(4'h9, 1, 5, 0);
        add(0, 0, 1, 1, 4'h9, 0, 0, 0, 0);
        add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        // 5: reset after four digits clears everything, held write fields included
        add(0, 1, 0, 0, 4'd0, 1, 0, 0, 0);
        add_key(4'h2, 1, 0, 0);
        add_key(4'h1, 1, 1, 0);
        add_key(4'h1, 1, 2, 0);
        add_key(4'h1, 1, 3, 0);
        add_key(4'h1, 1, 4, 0);
        hs = 2'd0; hc = 24'd0;
        add(1, 1, 0, 1, 4'h1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 4'h1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 4'h1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 4'd0, 0, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].cn, vecs[i].kv, vecs[i].kval);
            @(negedge clk);
            check($sformatf("vec[%0d] busy,dc,kerr,wr,slot,color,tmo", i),
                  {28'd0, busy, digit_count, key_err, wr_en, wr_slot, wr_color, timeout},
                  {28'd0, vecs[i].busy, vecs[i].dc, vecs[i].kerr, vecs[i].wr,
                   vecs[i].slot, vecs[i].color, vecs[i].tmo});
        end

        // 6: start, slot 0, two digits, then silence
        begin
            int tmo_at = -1;
            int wr_seen = 0;
            drive(0, 1, 0, 0, 4'd0); @(negedge clk);
            drive(0, 0, 0, 1, 4'h0); @(negedge clk);
            drive(0, 0, 0, 0, 4'h0); @(negedge clk);
            drive(0, 0, 0, 1, 4'hA); @(negedge clk);
            drive(0, 0, 0, 0, 4'h0); @(negedge clk);
            drive(0, 0, 0, 1, 4'hB); @(negedge clk);
            drive(0, 0, 0, 0, 4'h0);
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (wr_en) wr_seen++;
                if (timeout && tmo_at < 0) tmo_at = k;
            end
            check("no wr_en during idle wait", 64'(wr_seen), 64'd0);
`ifdef COLOR_ENTRY_TIMEOUT_EN
            check("timeout cycle after last key", 64'(tmo_at), 64'd16);
            check("busy after timeout", 64'(busy), 64'd0);
`else
            check("no timeout pulse", 64'(tmo_at), -64'sd1);
            check("still busy/dc=2", {62'd0, busy, digit_count == 3'd2}, 64'd3);
            drive(0, 0, 1, 0, 4'h0); @(negedge clk);
            drive(0, 0, 0, 0, 4'h0);
            check("busy after cancel", 64'(busy), 64'd0);
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
